// File: rtl/hms_pkg.sv
// Shared types, constants and hour-conversion helpers for the hh:mm:ss counter.
package hms_pkg;

  typedef logic [3:0] bcd_t;

  localparam int S0 = 0;
  localparam int S1 = 1;
  localparam int M0 = 2;
  localparam int M1 = 3;
  localparam int H0 = 4;
  localparam int H1 = 5;

  localparam bcd_t MOD_10 = 4'd10;
  localparam bcd_t MOD_6  = 4'd6;

  localparam logic [4:0] HOUR_MAX_24 = 5'd23;
  localparam logic [4:0] HOUR_MAX_12 = 5'd12;

  typedef struct packed {
    logic [4:0] hour;
    logic       pm;
  } h12_t;

  function automatic logic [6:0] bcd2_to_bin(input bcd_t tens, input bcd_t ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

  function automatic logic [7:0] bin_to_bcd2(input logic [4:0] v);
    if (v >= 5'd20)      return {4'd2, 4'(v - 5'd20)};
    else if (v >= 5'd10) return {4'd1, 4'(v - 5'd10)};
    else                 return {4'd0, 4'(v)};
  endfunction

  function automatic logic [4:0] hour_12_to_24(input logic [4:0] h12, input logic pm);
    if (h12 == HOUR_MAX_12) return pm ? HOUR_MAX_12 : 5'd0;
    else                    return pm ? h12 + HOUR_MAX_12 : h12;
  endfunction

  function automatic h12_t hour_24_to_12(input logic [4:0] h24);
    h12_t r;
    r.pm = (h24 >= HOUR_MAX_12);
    if (h24 == 5'd0)              r.hour = HOUR_MAX_12;
    else if (h24 > HOUR_MAX_12)   r.hour = h24 - HOUR_MAX_12;
    else                          r.hour = h24;
    return r;
  endfunction

  // Hour range is checked on raw digits so out-of-range BCD never reaches the binary path.
  function automatic logic load_valid(input logic [23:0] t, input logic is_24h);
    bcd_t h1, h0;
    logic ok;
    h1 = t[23:20];
    h0 = t[19:16];
    ok = (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) && (t[11:8] <= 4'd9) &&
         (t[15:12] <= 4'd5) && (h0 <= 4'd9) && (h1 <= 4'd9);
    if (is_24h)
      ok = ok && ((h1 < 4'd2) || (h1 == 4'd2 && h0 <= 4'd3));
    else
      ok = ok && ((h1 == 4'd0 && h0 >= 4'd1) || (h1 == 4'd1 && h0 <= 4'd2));
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counting modulo MOD in either direction, with load priority.
module bcd_digit
  import hms_pkg::*;
#(
  parameter bcd_t MOD = MOD_10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_dir,
  input  logic i_ld,
  input  bcd_t i_ld_val,
  output bcd_t o_value,
  output logic o_carry
);

  localparam bcd_t TOP = MOD - 4'd1;

  bcd_t r_value;
  logic w_term;

  assign w_term  = i_dir ? (r_value == 4'd0) : (r_value == TOP);
  assign o_carry = i_en & w_term;
  assign o_value = r_value;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= 4'd0;
    end else if (i_ld) begin
      r_value <= i_ld_val;
    end else if (i_en) begin
      if (i_dir) r_value <= w_term ? TOP : r_value - 4'd1;
      else       r_value <= w_term ? 4'd0 : r_value + 4'd1;
    end
  end

endmodule

// File: rtl/hms_time_counter.sv
// hh:mm:ss time-of-day counter: canonical 24 h BCD chain, 1 s prescaler, 12/24 h view, validated load.
module hms_time_counter
  import hms_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int PW       = $clog2(TICK_DIV)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        count_down,
  input  logic        mode_24h,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        load_pm,
  output logic [23:0] time_out,
  output logic        pm_out,
  output logic        tick_out,
  output logic        rollover,
  output logic        load_err
);

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  bcd_t          r_h1, r_h0;
  logic          r_tick, r_roll, r_err;

  logic          w_step, w_valid, w_ld_ok;
  logic [4:0]    w_ld_hour_in, w_ld_hour24;
  logic [7:0]    w_ld_hour_bcd;
  bcd_t          w_s0, w_s1, w_m0, w_m1;
  logic          w_cy_s0, w_cy_s1, w_cy_m0, w_cy_m1;
  logic          w_hour_wrap;
  logic [4:0]    w_h24;
  h12_t          w_h12;
  logic [7:0]    w_h12_bcd;

  // A coincident load (valid or not) suppresses the step.
  assign w_step  = run && (r_presc == PRESC_MAX) && !load;
  assign w_valid = load_valid(load_time, mode_24h);
  assign w_ld_ok = load && w_valid;

  assign w_ld_hour_in  = 5'(bcd2_to_bin(load_time[23:20], load_time[19:16]));
  assign w_ld_hour24   = mode_24h ? w_ld_hour_in : hour_12_to_24(w_ld_hour_in, load_pm);
  assign w_ld_hour_bcd = bin_to_bcd2(w_ld_hour24);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (load) begin
      if (w_valid) r_presc <= '0;
    end else if (run) begin
      r_presc <= w_step ? '0 : r_presc + PW'(1);
    end
  end

  bcd_digit #(.MOD(MOD_10)) u_s0 (
    .clk(clk), .reset_n(reset_n), .i_en(w_step), .i_dir(count_down),
    .i_ld(w_ld_ok), .i_ld_val(load_time[3:0]), .o_value(w_s0), .o_carry(w_cy_s0)
  );
  bcd_digit #(.MOD(MOD_6)) u_s1 (
    .clk(clk), .reset_n(reset_n), .i_en(w_cy_s0), .i_dir(count_down),
    .i_ld(w_ld_ok), .i_ld_val(load_time[7:4]), .o_value(w_s1), .o_carry(w_cy_s1)
  );
  bcd_digit #(.MOD(MOD_10)) u_m0 (
    .clk(clk), .reset_n(reset_n), .i_en(w_cy_s1), .i_dir(count_down),
    .i_ld(w_ld_ok), .i_ld_val(load_time[11:8]), .o_value(w_m0), .o_carry(w_cy_m0)
  );
  bcd_digit #(.MOD(MOD_6)) u_m1 (
    .clk(clk), .reset_n(reset_n), .i_en(w_cy_m0), .i_dir(count_down),
    .i_ld(w_ld_ok), .i_ld_val(load_time[15:12]), .o_value(w_m1), .o_carry(w_cy_m1)
  );

  // Hour pair wraps 23<->00, which no per-digit modulus can express.
  assign w_hour_wrap = w_cy_m1 &&
                       (count_down ? (r_h1 == 4'd0 && r_h0 == 4'd0)
                                   : (r_h1 == 4'd2 && r_h0 == 4'd3));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h1 <= 4'd0;
      r_h0 <= 4'd0;
    end else if (w_ld_ok) begin
      r_h1 <= w_ld_hour_bcd[7:4];
      r_h0 <= w_ld_hour_bcd[3:0];
    end else if (w_cy_m1) begin
      if (w_hour_wrap) begin
        r_h1 <= count_down ? 4'd2 : 4'd0;
        r_h0 <= count_down ? 4'd3 : 4'd0;
      end else if (count_down) begin
        if (r_h0 == 4'd0) begin
          r_h1 <= r_h1 - 4'd1;
          r_h0 <= 4'd9;
        end else begin
          r_h0 <= r_h0 - 4'd1;
        end
      end else begin
        if (r_h0 == 4'd9) begin
          r_h1 <= r_h1 + 4'd1;
          r_h0 <= 4'd0;
        end else begin
          r_h0 <= r_h0 + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick <= 1'b0;
      r_roll <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_tick <= w_step;
      r_roll <= w_hour_wrap;
      r_err  <= load && !w_valid;
    end
  end

  assign w_h24     = 5'(bcd2_to_bin(r_h1, r_h0));
  assign w_h12     = hour_24_to_12(w_h24);
  assign w_h12_bcd = bin_to_bcd2(w_h12.hour);

  assign time_out = mode_24h ? {r_h1, r_h0, w_m1, w_m0, w_s1, w_s0}
                             : {w_h12_bcd, w_m1, w_m0, w_s1, w_s0};
  assign pm_out   = !mode_24h && w_h12.pm;
  assign tick_out = r_tick;
  assign rollover = r_roll;
  assign load_err = r_err;

endmodule

// File: tb/tb_hms_time_counter.sv
// Directed self-checking bench for hms_time_counter with TICK_DIV=4.
module tb_hms_time_counter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run, count_down, mode_24h, load, load_pm;
  logic [23:0] load_time;
  logic [23:0] time_out;
  logic        pm_out, tick_out, rollover, load_err;

  int n_checks = 0;
  int n_errors = 0;

  hms_time_counter #(.TICK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .count_down(count_down),
    .mode_24h(mode_24h), .load(load), .load_time(load_time), .load_pm(load_pm),
    .time_out(time_out), .pm_out(pm_out), .tick_out(tick_out),
    .rollover(rollover), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [23:0] t, input logic pm);
    load      = 1'b1;
    load_time = t;
    load_pm   = pm;
    cyc(1);
    load      = 1'b0;
  endtask

  // Expect no step for n-1 cycles, then a step showing exp_t.
  task automatic expect_step(input int n, input logic [23:0] exp_t, input logic exp_pm,
                             input logic exp_roll, input string tag);
    for (int i = 0; i < n - 1; i++) begin
      cyc(1);
      check({tag, "_no_tick"}, {31'd0, tick_out}, 32'd0);
    end
    cyc(1);
    check({tag, "_tick"}, {31'd0, tick_out}, 32'd1);
    check({tag, "_time"}, {8'd0, time_out}, {8'd0, exp_t});
    check({tag, "_pm"}, {31'd0, pm_out}, {31'd0, exp_pm});
    check({tag, "_roll"}, {31'd0, rollover}, {31'd0, exp_roll});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; run = 1'b1; count_down = 1'b0; mode_24h = 1'b1;
    load = 1'b0; load_time = 24'h0; load_pm = 1'b0;
    #12;
    check("rst_time24", {8'd0, time_out}, 32'h000000);
    check("rst_tick", {29'd0, tick_out, rollover, load_err}, 32'd0);
    mode_24h = 1'b0;
    #1;
    check("rst_time12", {8'd0, time_out}, 32'h120000);
    check("rst_pm12", {31'd0, pm_out}, 32'd0);
    mode_24h = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;

    expect_step(4, 24'h000001, 1'b0, 1'b0, "first");

    do_load(24'h235959, 1'b0);
    check("ld_up_time", {8'd0, time_out}, 32'h235959);
    check("ld_up_err", {31'd0, load_err}, 32'd0);
    expect_step(4, 24'h000000, 1'b0, 1'b1, "up_wrap");
    mode_24h = 1'b0;
    #1;
    check("up_wrap_12h", {8'd0, time_out}, 32'h120000);
    check("up_wrap_12h_pm", {31'd0, pm_out}, 32'd0);

    count_down = 1'b1;
    do_load(24'h120000, 1'b0);
    check("ld_am12_time", {8'd0, time_out}, 32'h120000);
    expect_step(4, 24'h115959, 1'b1, 1'b1, "down_wrap");
    expect_step(4, 24'h115958, 1'b1, 1'b0, "down_next");

    count_down = 1'b0;
    do_load(24'h115959, 1'b0);
    expect_step(4, 24'h120000, 1'b1, 1'b0, "noon");

    run = 1'b0;
    mode_24h = 1'b1;
    do_load(24'h246000, 1'b0);
    check("bad24_err", {31'd0, load_err}, 32'd1);
    check("bad24_time", {8'd0, time_out}, 32'h120000);
    cyc(1);
    check("bad24_pulse", {31'd0, load_err}, 32'd0);
    mode_24h = 1'b0;
    do_load(24'h000000, 1'b0);
    check("bad12_zero_err", {31'd0, load_err}, 32'd1);
    check("bad12_zero_time", {7'd0, pm_out, time_out}, 32'h1120000);
    cyc(1);
    do_load(24'h126000, 1'b1);
    check("bad12_min_err", {31'd0, load_err}, 32'd1);
    cyc(1);
    mode_24h = 1'b1;
    do_load(24'h126000, 1'b0);
    check("bad24_min_err", {31'd0, load_err}, 32'd1);
    cyc(1);
    mode_24h = 1'b0;
    do_load(24'h130000, 1'b0);
    check("bad12_13_err", {31'd0, load_err}, 32'd1);
    check("bad12_13_time", {7'd0, pm_out, time_out}, 32'h1120000);
    cyc(1);
    check("bad12_13_pulse", {31'd0, load_err}, 32'd0);

    run = 1'b1;
    mode_24h = 1'b1;
    do_load(24'h010203, 1'b0);
    check("ld_010203", {8'd0, time_out}, 32'h010203);
    cyc(3);
    do_load(24'h050505, 1'b0);
    check("prio_time", {8'd0, time_out}, 32'h050505);
    check("prio_tick", {30'd0, tick_out, rollover}, 32'd0);
    expect_step(4, 24'h050506, 1'b0, 1'b0, "after_prio");

    cyc(2);
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("freeze_tick", {31'd0, tick_out}, 32'd0);
    end
    check("freeze_time", {8'd0, time_out}, 32'h050506);
    run = 1'b1;
    expect_step(2, 24'h050507, 1'b0, 1'b0, "resume");

    cyc(2);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_time", {8'd0, time_out}, 32'h000000);
    check("midrst_flags", {29'd0, tick_out, rollover, load_err}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    expect_step(4, 24'h000001, 1'b0, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hms_time_counter.md
# hms_time_counter

Parametrised hh:mm:ss time-of-day counter for the FPGA clock display. It replaces per-digit counting with one synchronous six-digit BCD carry/borrow chain and an internal one-second prescaler. It adds runtime 12/24-hour display mode, up/down counting and validated parallel load. It feeds the seven-segment display stage and is commanded by the control module's run/load outputs.

## Interface
Parameters:
- TICK_DIV, 50_000_000, clk cycles per count step (1 s at 50 MHz); must be ≥ 2.
- PW, $clog2(TICK_DIV), prescaler width (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- run  in  1  1 = prescaler advances and time counts; 0 = frozen.
- count_down  in  1  1 = decrement per step, 0 = increment.
- mode_24h  in  1  display/load interpretation: 1 = 24 h, 0 = 12 h.
- load  in  1  single-cycle strobe; loads load_time.
- load_time  in  24  BCD {H1,H0,M1,M0,S1,S0}, interpreted per mode_24h.
- load_pm  in  1  PM flag for 12 h loads; ignored in 24 h mode.
- time_out  out  24  displayed BCD {H1,H0,M1,M0,S1,S0}.
- pm_out  out  1  1 = PM; always 0 in 24 h mode.
- tick_out  out  1  one-cycle pulse coincident with each step update.
- rollover  out  1  one-cycle pulse when the chain wraps past midnight (either direction).
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- Canonical state is six registered BCD digits in 24 h form, 00:00:00–23:59:59. The 12 h view is combinational from the canonical state:
  - h=0 → 12 AM; 1–11 → h AM; 12 → 12 PM; 13–23 → h−12 PM.
- Prescaler: 0..TICK_DIV−1, advancing only when run=1. The step condition is run=1 and prescaler at TICK_DIV−1; on the step the prescaler goes to 0.
- Step, up: S0 increments with carry into S1 (mod 6), then M0, M1 (mod 6), then the hour pair. The hour pair counts 00→23 with 23→00 wrap. All carries resolve in the same cycle.
- Step, down: mirror borrow chain; 00:00:00 → 23:59:59.
- rollover pulses on 23:59:59→00:00:00 (up) and 00:00:00→23:59:59 (down).
- Load: validity checks:
  - every digit ≤ 9; S1 and M1 ≤ 5;
  - 24 h mode: hour ≤ 23;
  - 12 h mode: hour 01–12.
- Valid load: convert to canonical (12 AM→00, 12 PM→12, h PM→h+12) and write. The prescaler clears to 0.
- Invalid load: state and prescaler are unchanged, and load_err pulses.
- Simultaneous load and step: load wins, the step is discarded, and no tick_out or rollover occurs.
- mode_24h or count_down changes take effect immediately on the combinational view and on the next step. No state conversion is needed.
- run=0: prescaler holds its value; loads are still accepted.

## Timing
- Reset values (asynchronous, while reset_n=0): digits 00:00:00, prescaler 0, tick_out/rollover/load_err 0.
  - time_out reads 000000 in 24 h mode, or 120000 with pm_out=0 in 12 h mode.
- Step latency: digits update on the clock edge where the prescaler was TICK_DIV−1. tick_out and rollover are registered and high for exactly the following cycle, aligned with the new time_out.
- Load latency: load sampled at edge k. Effects visible after edge k:
  - new time_out and prescaler=0 (valid load), or
  - load_err high for one cycle (invalid load).
- Step spacing with run held high and no loads: exactly TICK_DIV cycles. The first step after a valid load comes TICK_DIV cycles after the load edge.
- Deasserting reset_n mid-count returns to reset values immediately. Counting resumes TICK_DIV cycles after release if run=1.

## Structure
- Package hms_pkg:
  - digit index constants (S0..H1) and BCD digit type;
  - moduli (10, 6), hour limits (23, 12);
  - 12↔24 h conversion functions and the validity-check function.
- Sub-module bcd_digit: one BCD digit with parameter MOD, inputs en/dir/ld/ld_val, outputs value and carry/borrow.
  - Instantiated for S0, S1, M0, M1.
  - The hour pair is a dedicated 0–23 two-digit block inside the top, because its wrap is not per-digit modulo.

## Test plan
Benches use TICK_DIV=4.
- Reset and display: reset, then run=1, mode_24h=1. Required: time_out=000000; first tick_out 4 cycles after release; time_out=000001.
- Up chain: load 235959 (24 h), 1 step. Required: 000000 with rollover=1 and tick_out=1 in the same cycle. Switching mode_24h=0 then shows 120000, pm_out=0.
- Down chain: count_down=1, load 12:00:00 AM (12 h). Required: one step gives 115959, pm_out=1, rollover=1; the next step gives 115958.
- 12 h noon: mode_24h=0, load 115959 AM, 1 step. Required: 120000, pm_out=1, no rollover.
- Invalid loads: 246000 in 24 h, 000000 in 12 h and 126000 in each gives one load_err pulse apiece with state unchanged. Then load 130000 in 12 h mode; required: load_err pulses, state unchanged.
- Priority and freeze:
  - load asserted on the step cycle: loaded value shown, no tick_out, next step 4 cycles later.
  - run=0 for 10 cycles: no step; the prescaler resumes from its held value.
